// File: rtl/drop_sequencer_if.sv
// rtl/drop_sequencer_if.sv - operator, drop handshake and status signals of the drop sequencer
interface drop_sequencer_if;
    logic       start;
    logic       abort;
    logic       ack;
    logic       drop_activated;
    logic       drop_en;
    logic       hatch_open;
    logic       busy;
    logic       done;
    logic       fault;
    logic [2:0] state;

    // Operator / display-block side: drives requests, observes status
    modport master (
        output start, abort, ack, drop_activated,
        input  drop_en, hatch_open, busy, done, fault, state
    );

    // Sequencer side
    modport slave (
        input  start, abort, ack, drop_activated,
        output drop_en, hatch_open, busy, done, fault, state
    );
endinterface

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - drop-enable initiator with confirm, timeout and hatch timing
module drop_sequencer #(
    parameter int CONFIRM_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int OPEN_CYCLES    = 50,
    parameter int CLOSE_CYCLES   = 10,
    parameter int CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    drop_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_OPEN  = 3'd2,
        ST_CLOSE = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] L_CONFIRM = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] L_OPEN    = CNT_W'(OPEN_CYCLES);
    localparam logic [CNT_W-1:0] L_CLOSE   = CNT_W'(CLOSE_CYCLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_confirm_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_confirm_nxt;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0] w_confirm_inc;
    logic [CNT_W-1:0] w_wait_inc;
    logic             r_done;

    // Counters never wrap: they hold once they reach their limit
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] lim);
        return (cnt == lim) ? cnt : cnt + CNT_W'(1);
    endfunction

    // State register and counters; reset overrides everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_confirm_cnt <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_confirm_cnt <= w_confirm_nxt;
            r_wait_cnt    <= w_wait_nxt;
        end
    end

    // Next state and counter updates; r_wait_cnt doubles as the phase timer in OPEN/CLOSE
    always_comb begin
        w_state_nxt   = r_state;
        w_confirm_nxt = '0;
        w_wait_nxt    = '0;
        w_confirm_inc = sat_inc(r_confirm_cnt, L_CONFIRM);
        w_wait_inc    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_wait_inc    = sat_inc(r_wait_cnt, L_TIMEOUT);
                w_wait_nxt    = w_wait_inc;
                w_confirm_nxt = bus.drop_activated ? w_confirm_inc : '0;
                // Abort beats confirm, confirm beats timeout
                if (bus.abort)
                    w_state_nxt = ST_IDLE;
                else if (bus.drop_activated && (w_confirm_inc == L_CONFIRM))
                    w_state_nxt = ST_OPEN;
                else if (w_wait_inc == L_TIMEOUT)
                    w_state_nxt = ST_FAULT;
            end
            ST_OPEN: begin
                w_wait_inc = sat_inc(r_wait_cnt, L_OPEN);
                w_wait_nxt = w_wait_inc;
                if (bus.abort || (w_wait_inc == L_OPEN)) w_state_nxt = ST_CLOSE;
            end
            ST_CLOSE: begin
                w_wait_inc = sat_inc(r_wait_cnt, L_CLOSE);
                w_wait_nxt = w_wait_inc;
                if (w_wait_inc == L_CLOSE) w_state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Every state entry starts with fresh counters
        if (w_state_nxt != r_state) begin
            w_confirm_nxt = '0;
            w_wait_nxt    = '0;
        end
    end

    // Completion pulse for the first IDLE cycle after CLOSE
    always_ff @(posedge i_clk) begin
        if (i_rst) r_done <= 1'b0;
        else       r_done <= (r_state == ST_CLOSE) && (w_state_nxt == ST_IDLE);
    end

    assign bus.drop_en    = (r_state == ST_REQ) || (r_state == ST_OPEN);
    assign bus.hatch_open = (r_state == ST_OPEN);
    assign bus.busy       = (r_state == ST_REQ) || (r_state == ST_OPEN) || (r_state == ST_CLOSE);
    assign bus.fault      = (r_state == ST_FAULT);
    assign bus.done       = r_done;
    assign bus.state      = r_state;

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Initiator side of the drop-enable / drop-activated handshake with the display-and-drop block.
- Accepts an operator start request and raises drop_en to the display block.
- Confirms that drop_activated stays high long enough, then times the baggage hatch open and close sequence.
- Flags a fault (baggage too hot) if confirmation never arrives.

Parameters:
- CONFIRM_CYCLES, 4: consecutive drop_activated=1 samples required in REQ before opening.
- TIMEOUT_CYCLES, 1000: maximum cycles spent in REQ before FAULT.
- OPEN_CYCLES, 50: cycles hatch_open is held high.
- CLOSE_CYCLES, 10: guard cycles after the hatch closes, before done.
- CNT_W, 16: width of the internal counters. It must hold the largest of the cycle-count parameters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operator request; sampled only in IDLE.
- abort  input  1  operator cancel.
- ack  input  1  fault acknowledge; sampled only in FAULT.
- drop_activated  input  1  response from the display-and-drop block.
- drop_en  output  1  request to the display-and-drop block.
- hatch_open  output  1  hatch actuator drive.
- busy  output  1  high in every state except IDLE and FAULT.
- done  output  1  one-cycle completion pulse.
- fault  output  1  high while in FAULT.
- state  output  3  debug encoding: IDLE=0, REQ=1, OPEN=2, CLOSE=3, FAULT=4.

Behaviour:
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- Reset: state=IDLE; drop_en, hatch_open, busy, done and fault all 0; counters 0. rst overrides every other input on any cycle, including mid-OPEN, where the hatch closes immediately.
- IDLE:
  - start=1 at edge k → REQ after edge k; drop_en=1 and busy=1 from that cycle.
  - abort and ack are ignored.
- REQ (drop_en=1):
  - Each edge, confirm_cnt increments if drop_activated=1 and clears to 0 if drop_activated=0.
  - wait_cnt increments every edge.
  - When confirm_cnt reaches CONFIRM_CYCLES → OPEN.
  - Otherwise, when wait_cnt reaches TIMEOUT_CYCLES → FAULT.
  - Confirm and timeout on the same edge → OPEN (confirm wins).
  - abort=1 → IDLE with drop_en=0 and no done pulse. abort beats confirm.
- OPEN:
  - drop_en=1, hatch_open=1 for exactly OPEN_CYCLES cycles, then → CLOSE.
  - drop_activated is ignored; the hatch stays open for the full duration.
  - abort=1 → CLOSE on the next edge.
  - start is ignored.
- CLOSE:
  - drop_en=0, hatch_open=0 for exactly CLOSE_CYCLES cycles, then → IDLE.
  - done=1 for exactly the first IDLE cycle, whether CLOSE was reached normally or by abort.
  - abort and start are ignored.
- FAULT:
  - drop_en=0, hatch_open=0, busy=0, fault=1.
  - Held until ack=1 → IDLE with fault=0 and no done pulse.
  - start is ignored.
- start held high continuously: one sequence per IDLE visit. A new sequence starts on the first IDLE cycle after done.
- Counters clear on every state entry. Counter width is CNT_W with no wrap: each counter is compared for equality and stops at its limit.
- hatch_open=1 implies drop_en=1 in every cycle; this is asserted in the bench.

Test Plan (CONFIRM=2, TIMEOUT=8, OPEN=5, CLOSE=3):
- Nominal drop:
  - Stimulus: start pulse at edge 0, drop_activated=1 constant.
  - Response: drop_en=1 from cycle 1; OPEN entered after edge 2; hatch_open=1 for cycles 3–7; CLOSE for cycles 8–10; done=1 in cycle 11 only; busy=0 from cycle 11.
- Glitching confirm:
  - Stimulus: drop_activated pattern 1,0,1,1 in REQ.
  - Response: confirm_cnt resets on the 0; OPEN entered only after the second consecutive 1.
- Hot bag:
  - Stimulus: start, drop_activated=0 constant.
  - Response: REQ for exactly 8 cycles, then fault=1 and drop_en=0. Holding ack=0 for 20 cycles keeps fault=1; an ack pulse returns to IDLE with done=0.
- Boundary:
  - Stimulus: drop_activated rises so that the second consecutive 1 lands on REQ cycle 8.
  - Response: OPEN, not FAULT.
- Abort:
  - Stimulus: abort during REQ.
  - Response: IDLE next cycle, no done.
  - Stimulus: abort in OPEN cycle 2.
  - Response: hatch_open=0 next cycle, then 3 CLOSE cycles, then done=1.
- Reset mid-OPEN:
  - Stimulus: rst=1 for one cycle in OPEN.
  - Response: all outputs 0 and state=0 next cycle; a start asserted during rst is ignored.
